// File: rtl/regfile_pkg.sv
// Shared constants and write-qualification helpers for the 2-read/1-write register bank.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;

    function automatic logic in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

    // A write is legal when enabled, addressed inside the array and not aimed at a hard-wired zero word.
    function automatic logic wr_legal(input logic we, input int unsigned addr,
                                      input int unsigned depth, input logic zero_r0);
        return we && in_range(addr, depth) && !(zero_r0 && addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_2r1w_word.sv
// One storage word: WIDTH-bit register with load enable and asynchronous active-low clear.
module reg_word
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: every word is cleared by reset because the bank must read as zero straight after reset;
    // sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/regfile_2r1w.sv
// General-purpose register bank: one synchronous write port, two combinational read ports with optional write-through.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             werr
);

    logic [WIDTH-1:0] w_words [DEPTH];
    logic             w_legal;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic             r_werr;

    assign w_legal = wr_legal(we, 32'(waddr), DEPTH, ZERO_R0);

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        if (ZERO_R0 && g == 0) begin : g_zero
            assign w_words[g] = '0;
        end else begin : g_reg
            logic w_en;
            assign w_en = w_legal && (waddr == AW'(g));
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_en),
                .d     (wdata),
                .q     (w_words[g])
            );
        end
    end

    // NOTE: both read results get a default first, so an address matching no word reads zero and no latch is inferred.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) w_rd_a = w_words[i];
            if (raddr_b == AW'(i)) w_rd_b = w_words[i];
        end
        // Write-through is not gated by reset: a live legal write is forwarded even while the array is held clear.
        if (BYPASS && w_legal && raddr_a == waddr) w_rd_a = wdata;
        if (BYPASS && w_legal && raddr_b == waddr) w_rd_b = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_werr <= 1'b0;
        end else if (we) begin
            r_werr <= !in_range(32'(waddr), DEPTH);
        end
    end

    assign rdata_a = w_rd_a;
    assign rdata_b = w_rd_b;
    assign werr    = r_werr;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: four parameter variants driven from one shared stimulus bus.
module tb_regfile_2r1w;

    // Variant 0: bypass, 1: no bypass, 2: zero word 0, 3: DEPTH=6
    localparam int DEP [4] = '{8, 8, 8, 6};
    localparam bit ZR  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [7:0] rd_a [4];
    logic [7:0] rd_b [4];
    logic       werr_o [4];

    logic [7:0] mdl [4][8];
    logic       werr_m [4];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[0]), .raddr_b(raddr_b), .rdata_b(rd_b[0]), .werr(werr_o[0]));
    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[1]), .raddr_b(raddr_b), .rdata_b(rd_b[1]), .werr(werr_o[1]));
    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_zero (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[2]), .raddr_b(raddr_b), .rdata_b(rd_b[2]), .werr(werr_o[2]));
    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_d6 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rd_a[3]), .raddr_b(raddr_b), .rdata_b(rd_b[3]), .werr(werr_o[3]));

    // Stored-value reference for a non-bypassed read
    function automatic logic [7:0] exp_rd(input int k, input logic [2:0] a);
        if (int'(a) >= DEP[k] || (ZR[k] && a == 3'd0)) return 8'h00;
        return mdl[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            werr_m[k] = 1'b0;
            for (int i = 0; i < 8; i++) mdl[k][i] = 8'h00;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            if (we) begin
                werr_m[k] = (int'(waddr) >= DEP[k]);
                if (int'(waddr) < DEP[k] && !(ZR[k] && waddr == 3'd0)) mdl[k][waddr] = wdata;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 8'h00 || rd_b[k] !== 8'h00 || werr_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got a=%h b=%h werr=%b, want 00 00 0", k, rd_a[k], rd_b[k], werr_o[k]);
            end
        end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        cycle();
        waddr = 3'd7; wdata = 8'h77;
        cycle();
        we = 1'b0; raddr_a = 3'd3;
        #1;
        checks++;
        if (rd_a[0] !== 8'hA5) begin
            errors++; $display("FAIL pre_reset_read: got %h want a5", rd_a[0]);
        end
        checks++;
        if (werr_o[3] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_werr: got %b want 1", werr_o[3]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 8'h00 || werr_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset[%0d]: got a=%h werr=%b, want 00 0", k, rd_a[k], werr_o[k]);
            end
        end
        #2 rst_n = 1'b1;
        model_reset();
        // Reset held across a clock edge with a write pending: nothing may be stored
        we = 1'b1; waddr = 3'd4; wdata = 8'h99;
        @(negedge clk);
        #4 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; we = 1'b0; raddr_a = 3'd4;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 8'h00) begin
                errors++; $display("FAIL reset_at_edge[%0d]: got %h want 00", k, rd_a[k]);
            end
        end
    endtask

    task automatic test_latency_bypass();
        we = 1'b1; waddr = 3'd5; wdata = 8'h3C; raddr_a = 3'd5; raddr_b = 3'd5;
        #1;
        checks++;
        if (rd_a[1] !== 8'h00 || rd_b[1] !== 8'h00) begin
            errors++; $display("FAIL nobyp_pre_edge: got a=%h b=%h want 00 00", rd_a[1], rd_b[1]);
        end
        checks++;
        if (rd_a[0] !== 8'h3C || rd_b[0] !== 8'h3C || rd_a[3] !== 8'h3C) begin
            errors++; $display("FAIL bypass_both: got a=%h b=%h d6=%h want 3c", rd_a[0], rd_b[0], rd_a[3]);
        end
        cycle();
        we = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_a[k] !== 8'h3C || rd_b[k] !== 8'h3C) begin
                errors++; $display("FAIL stored_read[%0d]: got a=%h b=%h want 3c 3c", k, rd_a[k], rd_b[k]);
            end
        end
        // Overwrite: without bypass the old value stays visible until the edge
        we = 1'b1; wdata = 8'h5A;
        #1;
        checks++;
        if (rd_a[1] !== 8'h3C || rd_a[0] !== 8'h5A) begin
            errors++; $display("FAIL overwrite_pre_edge: got nobyp=%h byp=%h want 3c 5a", rd_a[1], rd_a[0]);
        end
        cycle();
        we = 1'b0;
        #1;
        checks++;
        if (rd_b[1] !== 8'h5A) begin
            errors++; $display("FAIL overwrite_post_edge: got %h want 5a", rd_b[1]);
        end
    endtask

    task automatic test_zero_r0();
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0; raddr_b = 3'd0;
        #1;
        checks++;
        if (rd_a[2] !== 8'h00 || rd_b[2] !== 8'h00) begin
            errors++; $display("FAIL zero_no_bypass: got a=%h b=%h want 00 00", rd_a[2], rd_b[2]);
        end
        cycle();
        we = 1'b0;
        #1;
        checks++;
        if (rd_a[2] !== 8'h00 || werr_o[2] !== 1'b0) begin
            errors++; $display("FAIL zero_discard: got a=%h werr=%b want 00 0", rd_a[2], werr_o[2]);
        end
        checks++;
        if (rd_a[0] !== 8'hFF || rd_a[1] !== 8'hFF) begin
            errors++; $display("FAIL word0_normal: got byp=%h nobyp=%h want ff ff", rd_a[0], rd_a[1]);
        end
    endtask

    task automatic test_out_of_range();
        we = 1'b1; waddr = 3'd7; wdata = 8'h77; raddr_a = 3'd7; raddr_b = 3'd5;
        #1;
        checks++;
        if (rd_a[3] !== 8'h00 || rd_a[0] !== 8'h77) begin
            errors++; $display("FAIL oor_no_bypass: got d6=%h byp=%h want 00 77", rd_a[3], rd_a[0]);
        end
        cycle();
        we = 1'b0;
        #1;
        checks++;
        if (werr_o[3] !== 1'b1 || werr_o[0] !== 1'b0 || rd_a[3] !== 8'h00) begin
            errors++; $display("FAIL oor_werr: got werr=%b/%b a=%h want 1/0 00", werr_o[3], werr_o[0], rd_a[3]);
        end
        for (int i = 0; i < 6; i++) begin
            raddr_a = 3'(i);
            #1;
            checks++;
            if (rd_a[3] !== exp_rd(3, 3'(i))) begin
                errors++; $display("FAIL oor_unchanged[%0d]: got %h want %h", i, rd_a[3], exp_rd(3, 3'(i)));
            end
        end
        cycle();
        checks++;
        if (werr_o[3] !== 1'b1) begin
            errors++; $display("FAIL werr_hold: got %b want 1", werr_o[3]);
        end
        we = 1'b1; waddr = 3'd2; wdata = 8'h11; raddr_a = 3'd2;
        cycle();
        we = 1'b0;
        #1;
        checks++;
        if (werr_o[3] !== 1'b0 || rd_a[3] !== 8'h11) begin
            errors++; $display("FAIL werr_clear: got werr=%b a=%h want 0 11", werr_o[3], rd_a[3]);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 8'(i * 17);
            cycle();
        end
        we = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (werr_o[k] !== werr_m[k]) begin
                errors++; $display("FAIL sweep_werr[%0d]: got %b want %b", k, werr_o[k], werr_m[k]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd_a[k] !== exp_rd(k, 3'(i)) || rd_b[k] !== exp_rd(k, 3'(7 - i))) begin
                    errors++;
                    $display("FAIL sweep[%0d][%0d]: got a=%h b=%h want %h %h", k, i,
                             rd_a[k], rd_b[k], exp_rd(k, 3'(i)), exp_rd(k, 3'(7 - i)));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid();
        test_latency_bypass();
        test_zero_r0();
        test_out_of_range();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised multi-bit storage array, the clocked successor to the single-bit D storage element.
- Holds DEPTH words of WIDTH bits.
- One synchronous write port and two independent combinational read ports.
- Used as the general-purpose register bank for the teaching datapath (ALU operands A/B, writeback port).

Parameters:
- WIDTH, 8, bits per word (1..32)
- DEPTH, 8, number of words (2..32, need not be a power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_R0, 0, when 1 word 0 is hard-wired to zero and writes to it are discarded
- BYPASS, 1, when 1 a read of the address being written this cycle returns wdata (write-through)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable, sampled at rising clk
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- raddr_a  input  AW  read address, port A
- rdata_a  output  WIDTH  read data, port A
- raddr_b  input  AW  read address, port B
- rdata_b  output  WIDTH  read data, port B
- werr  output  1  registered flag: last sampled write was rejected (out of range)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, any time, independent of clk):
  - all DEPTH words clear to 0 immediately
  - werr clears to 0
  - rdata_a/rdata_b follow to 0 combinationally (unless BYPASS forwards a live write; see the bypass rules below).
  - Writes are blocked while rst_n=0.
- Reset release: the first rising clk edge with rst_n=1 may write.
- Write, at the rising clk edge:
  - Condition: we=1 and waddr<DEPTH, and not (ZERO_R0=1 and waddr=0).
  - Effect: mem[waddr] <= wdata.
  - Latency: the stored value is visible on a non-bypassed read the cycle after the edge.
- Out-of-range write (we=1, waddr>=DEPTH):
  - memory is unchanged
  - werr <= 1 at that edge.
  - Any other edge with we=1 and in-range waddr sets werr <= 0.
  - Edges with we=0 hold werr.
- Write to word 0 with ZERO_R0=1:
  - silently discarded
  - not an error (werr <= 0).
- Read (combinational, zero latency):
  - rdata_x = mem[raddr_x].
  - raddr_x >= DEPTH returns 0.
  - ZERO_R0=1 and raddr_x=0 returns 0.
- Bypass (BYPASS=1):
  - Condition: we=1, waddr=raddr_x, and the write is legal.
  - Effect: rdata_x = wdata in the same cycle, before the edge.
  - Both ports may bypass simultaneously.
  - Illegal writes never bypass.
  - With BYPASS=0, rdata shows the old value until after the edge.
- Simultaneous events:
  - Both read ports on the same address return identical data.
  - Reset asserted coincident with a clk edge: reset wins, nothing written.
- No X propagation: every output is defined for all input combinations after reset.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/DEPTH constants
  - function in_range(addr, DEPTH)
  - function wr_legal(we, addr, DEPTH, ZERO_R0)
- Natural sub-module: reg_word
  - function: WIDTH-bit register with enable and async active-low clear
  - Instantiated DEPTH times via generate; word 0 is tied to 0 when ZERO_R0=1.
- Read muxes and bypass compare stay in the top level.

Test Plan:
- Reset mid-operation:
  - Stimulus: write 0xA5 to word 3, then pulse rst_n low between clock edges.
  - Required: rdata_a (raddr_a=3) goes to 0x00 without a clk edge, and werr=0.
- Write/read latency, BYPASS=0:
  - Stimulus: we=1, waddr=5, wdata=0x3C, raddr_a=5.
  - Required: rdata_a shows the old value 0x00 before the edge and 0x3C after it; raddr_b=5 also reads 0x3C.
- Bypass, BYPASS=1:
  - Stimulus: same cycle as the previous write, raddr_a=raddr_b=5.
  - Required: both read 0x3C before the edge.
  - Stimulus: we=0.
  - Required: both read the stored value.
- ZERO_R0=1:
  - Stimulus: write 0xFF to word 0.
  - Required: rdata_a (raddr_a=0) stays 0x00, no bypass, werr=0.
- Out-of-range, DEPTH=6 (AW=3):
  - Stimulus: write 0x77 to waddr=7.
  - Required: werr=1 after the edge, all words unchanged, raddr_a=7 reads 0x00.
  - Stimulus: next legal write.
  - Required: werr=0.
- Full sweep:
  - Stimulus: write word i = i*17 (mod 2^WIDTH) for i = 0..DEPTH-1, then read all via both ports in opposite orders.
  - Required: every word matches; word 0 = 0 when ZERO_R0=1.
